noc_ingress_queue: RTL and testbench

NOC_INGRESS_QUEUE -- requirements
Module: noc_ingress_queue

---
 rtl/noc_ingress_queue.sv | 78 +++++++
 tb/tb_noc_ingress_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_ingress_queue.sv
// rtl/noc_ingress_queue.sv - first-word-fall-through packet queue between the core NoC bus and the memory interface
module noc_ingress_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 fclk,
  input  logic                 rst,
  input  logic [31:0][7:0]     inp_dat,
  input  logic [5:0]           inp_bp,
  input  logic                 inp_bo,
  output logic                 inp_rdy,
  input  logic                 flush,
  output logic [31:0][7:0]     oup_dat,
  output logic [5:0]           oup_bp,
  output logic                 oup_bo,
  input  logic                 oup_rdy,
  output logic [CW-1:0]        occupancy,
  output logic                 almost_full,
  output logic                 ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0][7:0] mem_dat [DEPTH];
  logic [5:0]       mem_bp  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshakes decode from registered occupancy only, so no input reaches an output combinationally.
  assign inp_rdy     = (occupancy != CW'(DEPTH));
  assign oup_bo      = (occupancy != '0);
  assign almost_full = (occupancy >= CW'(DEPTH - 1));
  assign push        = inp_bo && inp_rdy && !flush;
  assign pop         = oup_bo && oup_rdy && !flush;

  assign oup_dat = oup_bo ? mem_dat[rd_ptr] : '0;
  assign oup_bp  = oup_bo ? mem_bp[rd_ptr]  : '0;

  // Payload slots carry no reset; the zero mask above hides stale contents.
  always_ff @(posedge fclk) begin
    if (push) begin
      mem_dat[wr_ptr] <= inp_dat;
      mem_bp[wr_ptr]  <= inp_bp;
    end
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Sticky until reset; an offer against a full queue counts even during flush.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (inp_bo && !inp_rdy) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_ingress_queue.sv
// tb/tb_noc_ingress_queue.sv - directed self-checking bench for noc_ingress_queue
module tb_noc_ingress_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             fclk;
  logic             rst;
  logic [31:0][7:0] inp_dat;
  logic [5:0]       inp_bp;
  logic             inp_bo;
  logic             inp_rdy;
  logic             flush;
  logic [31:0][7:0] oup_dat;
  logic [5:0]       oup_bp;
  logic             oup_bo;
  logic             oup_rdy;
  logic [CW-1:0]    occupancy;
  logic             almost_full;
  logic             ovf;

  int checks;
  int failures;

  noc_ingress_queue #(.DEPTH(DEPTH)) dut (
    .fclk        (fclk),
    .rst         (rst),
    .inp_dat     (inp_dat),
    .inp_bp      (inp_bp),
    .inp_bo      (inp_bo),
    .inp_rdy     (inp_rdy),
    .flush       (flush),
    .oup_dat     (oup_dat),
    .oup_bp      (oup_bp),
    .oup_bo      (oup_bo),
    .oup_rdy     (oup_rdy),
    .occupancy   (occupancy),
    .almost_full (almost_full),
    .ovf         (ovf)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  function automatic logic [31:0][7:0] make_dat(input int k);
    logic [31:0][7:0] d;
    for (int b = 0; b < 32; b++) d[b] = 8'((k * 37 + b * 11 + 5) & 8'hff);
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b0; inp_bo = 1'b0; inp_dat = '0; inp_bp = '0; flush = 1'b0; oup_rdy = 1'b0;
    #1;
    checks++;
    if ({inp_rdy, oup_bo, almost_full, ovf} !== 4'b1000 || occupancy !== '0 ||
        oup_dat !== '0 || oup_bp !== '0) begin
      failures++;
      $display("FAIL reset_state: rdy/bo/af/ovf=%b occ=%0d bp=%h dat0=%h required 1000 0 0 0",
               {inp_rdy, oup_bo, almost_full, ovf}, occupancy, oup_bp, oup_dat[0]);
    end
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    oup_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      inp_bo = 1'b1; inp_bp = 6'(i); inp_dat = make_dat(i);
      tick();
      checks++;
      if (occupancy !== CW'(i) || almost_full !== (i >= 3) || inp_rdy !== (i < 4) || oup_bp !== 6'd1) begin
        failures++;
        $display("FAIL fill_%0d: occ=%0d af=%b rdy=%b head_bp=%0d required occ=%0d af=%b rdy=%b head_bp=1",
                 i, occupancy, almost_full, inp_rdy, oup_bp, i, (i >= 3), (i < 4));
      end
    end
    inp_bo = 1'b0;
  endtask

  task automatic test_full_ovf();
    inp_bo = 1'b1; inp_bp = 6'd5; inp_dat = make_dat(5); oup_rdy = 1'b1;
    tick();
    inp_bo = 1'b0;
    checks++;
    if (occupancy !== CW'(3) || ovf !== 1'b1 || oup_bp !== 6'd2) begin
      failures++;
      $display("FAIL full_ovf: occ=%0d ovf=%b head_bp=%0d required occ=3 ovf=1 head_bp=2",
               occupancy, ovf, oup_bp);
    end
    for (int i = 2; i <= 4; i++) begin
      checks++;
      if (oup_bo !== 1'b1 || oup_bp !== 6'(i) || oup_dat !== make_dat(i)) begin
        failures++;
        $display("FAIL drain_%0d: bo=%b bp=%0d required bo=1 bp=%0d", i, oup_bo, oup_bp, i);
      end
      tick();
    end
    checks++;
    if (oup_bo !== 1'b0 || occupancy !== '0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty: bo=%b occ=%0d ovf=%b required bo=0 occ=0 ovf=1", oup_bo, occupancy, ovf);
    end
    oup_rdy = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    oup_rdy = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      inp_bo = 1'b1; inp_bp = 6'(i); inp_dat = make_dat(i);
      tick();
    end
    inp_bp = 6'd9; inp_dat = make_dat(9); oup_rdy = 1'b1;
    tick();
    inp_bo = 1'b0;
    checks++;
    if (occupancy !== CW'(2) || oup_bp !== 6'd2) begin
      failures++;
      $display("FAIL simul_occ: occ=%0d head_bp=%0d required occ=2 head_bp=2", occupancy, oup_bp);
    end
    tick();
    checks++;
    if (occupancy !== CW'(1) || oup_bp !== 6'd9 || oup_dat !== make_dat(9)) begin
      failures++;
      $display("FAIL simul_order: occ=%0d head_bp=%0d required occ=1 head_bp=9", occupancy, oup_bp);
    end
    tick();
    oup_rdy = 1'b0;
    checks++;
    if (oup_bo !== 1'b0 || occupancy !== '0) begin
      failures++;
      $display("FAIL simul_empty: bo=%b occ=%0d required bo=0 occ=0", oup_bo, occupancy);
    end
  endtask

  task automatic test_latency();
    logic [31:0][7:0] d;
    d = '0;
    d[0] = 8'hA5;
    d[31] = 8'h5A;
    oup_rdy = 1'b0; inp_bo = 1'b1; inp_bp = 6'h3F; inp_dat = d;
    #1;
    checks++;
    if (oup_bo !== 1'b0 || oup_dat !== '0 || oup_bp !== '0) begin
      failures++;
      $display("FAIL empty_zero: bo=%b bp=%h dat0=%h required bo=0 bp=0 dat=0", oup_bo, oup_bp, oup_dat[0]);
    end
    tick();
    inp_bo = 1'b0;
    checks++;
    if (oup_bo !== 1'b1 || oup_dat !== d || oup_bp !== 6'h3F || occupancy !== CW'(1)) begin
      failures++;
      $display("FAIL latency: bo=%b dat0=%h bp=%h occ=%0d required bo=1 dat0=a5 bp=3f occ=1",
               oup_bo, oup_dat[0], oup_bp, occupancy);
    end
    oup_rdy = 1'b1;
    tick();
    oup_rdy = 1'b0;
    checks++;
    if (oup_bo !== 1'b0 || oup_dat !== '0 || oup_bp !== '0) begin
      failures++;
      $display("FAIL pop_zero: bo=%b dat0=%h bp=%h required all zero", oup_bo, oup_dat[0], oup_bp);
    end
  endtask

  task automatic test_stream();
    int tx = 0;
    int rx = 0;
    int cycles = 0;
    while (rx < 12 && cycles < 500) begin
      inp_bo  = (tx < 12);
      inp_bp  = 6'(tx + 20);
      inp_dat = make_dat(tx + 20);
      oup_rdy = 1'($urandom_range(0, 1));
      #1;
      if (oup_bo && oup_rdy) begin
        checks++;
        if (oup_bp !== 6'(rx + 20) || oup_dat !== make_dat(rx + 20)) begin
          failures++;
          $display("FAIL stream_%0d: bp=%0d required %0d", rx, oup_bp, rx + 20);
        end
        rx++;
      end
      if (inp_bo && inp_rdy) tx++;
      tick();
      cycles++;
    end
    inp_bo = 1'b0; oup_rdy = 1'b0;
    checks++;
    if (rx != 12 || oup_bo !== 1'b0) begin
      failures++;
      $display("FAIL stream_done: received=%0d bo=%b required received=12 bo=0", rx, oup_bo);
    end
  endtask

  task automatic test_flush();
    oup_rdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      inp_bo = 1'b1; inp_bp = 6'(i + 40); inp_dat = make_dat(i + 40);
      tick();
    end
    inp_bp = 6'd50; flush = 1'b1; oup_rdy = 1'b1;
    tick();
    inp_bo = 1'b0; flush = 1'b0; oup_rdy = 1'b0;
    checks++;
    if (occupancy !== '0 || oup_bo !== 1'b0 || ovf !== 1'b1 || inp_rdy !== 1'b1 || oup_bp !== '0) begin
      failures++;
      $display("FAIL flush: occ=%0d bo=%b ovf=%b rdy=%b required occ=0 bo=0 ovf=1 rdy=1",
               occupancy, oup_bo, ovf, inp_rdy);
    end
    inp_bo = 1'b1; inp_bp = 6'd7; inp_dat = make_dat(7);
    tick();
    inp_bo = 1'b0;
    checks++;
    if (occupancy !== CW'(1) || oup_bp !== 6'd7 || oup_dat !== make_dat(7)) begin
      failures++;
      $display("FAIL post_flush_push: occ=%0d bp=%0d required occ=1 bp=7", occupancy, oup_bp);
    end
  endtask

  task automatic test_reset_mid();
    inp_bo = 1'b1; inp_bp = 6'd11; inp_dat = make_dat(11);
    tick();
    inp_bo = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({inp_rdy, oup_bo, almost_full, ovf} !== 4'b1000 || occupancy !== '0 ||
        oup_dat !== '0 || oup_bp !== '0) begin
      failures++;
      $display("FAIL reset_mid: rdy/bo/af/ovf=%b occ=%0d bp=%h required 1000 occ=0 bp=0",
               {inp_rdy, oup_bo, almost_full, ovf}, occupancy, oup_bp);
    end
    #1 rst = 1'b1;
    tick();
    checks++;
    if (oup_bo !== 1'b0 || occupancy !== '0) begin
      failures++;
      $display("FAIL reset_release: bo=%b occ=%0d required bo=0 occ=0", oup_bo, occupancy);
    end
    inp_bo = 1'b1; inp_bp = 6'd12; inp_dat = make_dat(12);
    tick();
    inp_bo = 1'b0;
    checks++;
    if (oup_bo !== 1'b1 || oup_bp !== 6'd12 || occupancy !== CW'(1)) begin
      failures++;
      $display("FAIL reset_first_push: bo=%b bp=%0d occ=%0d required bo=1 bp=12 occ=1",
               oup_bo, oup_bp, occupancy);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_full_ovf();
    test_simul_push_pop();
    test_latency();
    test_stream();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
